// File: rtl/pc_redirect_controller_pkg.sv
// Shared definitions for the fetch-stage PC redirect controller.
package pc_redirect_controller_pkg;

  localparam int unsigned ADDR_W_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0040_0000;
  // Low PC bits that must be zero for a word-aligned fetch address
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PENDING = 2'b10
  } state_e;

endpackage

// File: rtl/pc_redirect_controller.sv
// Fetch-stage PC owner: arbitrates sequential fetch, ID jumps, EX redirects
// and stalls against the imem ready handshake, and drives pipeline flushes.
// Optional build macro: BRANCH_DELAY_SLOT_EN (honour the MIPS delay slot).
module pc_redirect_controller
  import pc_redirect_controller_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              id_jump_i,
  input  logic [ADDR_W-1:0] id_jump_target_i,
  input  logic              ex_redirect_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              fetch_valid_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              redirect_busy_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_e            state_q, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic [ADDR_W-1:0] pending_q, pending_nxt;
  logic              fetch_valid_q;
  logic              busy_q;
  logic              misalign_q;

  logic              accept_ex_c;
  logic              accept_id_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] raw_target_c;
  logic [ADDR_W-1:0] target_c;
  logic              misalign_c;

  // Redirect acceptance: EX beats ID; ID jumps only count in RUN without a stall
  always_comb begin
    accept_ex_c  = ex_redirect_i && ((state_q == ST_RUN) || (state_q == ST_PENDING));
    accept_id_c  = id_jump_i && !ex_redirect_i && !stall_i && (state_q == ST_RUN);
    redirect_c   = accept_ex_c || accept_id_c;
    raw_target_c = ex_redirect_i ? ex_target_i : id_jump_target_i;
    target_c     = {raw_target_c[ADDR_W-1:2], raw_target_c[1:0] & ~WORD_ALIGN_MASK};
    misalign_c   = redirect_c && (|(raw_target_c[1:0] & WORD_ALIGN_MASK));
  end

  // State, PC and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + PC_STEP;
      pending_q     <= '0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      pc_q          <= pc_nxt;
      pc_plus4_q    <= pc_nxt + PC_STEP;
      pending_q     <= pending_nxt;
      fetch_valid_q <= (state_nxt == ST_RUN);
      busy_q        <= (state_nxt == ST_PENDING);
      misalign_q    <= misalign_c;
    end
  end

  // Next state plus next-PC priority mux; a redirect the imem cannot take is parked
  always_comb begin
    state_nxt   = state_q;
    pc_nxt      = pc_q;
    pending_nxt = pending_q;
    case (state_q)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_c) begin
          if (imem_ready_i) begin
            pc_nxt = target_c;
          end else begin
            state_nxt   = ST_PENDING;
            pending_nxt = target_c;
          end
        end else if (!stall_i && imem_ready_i) begin
          pc_nxt = pc_q + PC_STEP;
        end
      end
      ST_PENDING: begin
        if (accept_ex_c) begin
          if (imem_ready_i) begin
            pc_nxt    = target_c;
            state_nxt = ST_RUN;
          end else begin
            pending_nxt = target_c;
          end
        end else if (imem_ready_i) begin
          pc_nxt    = pending_q;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // Flushes fire only in the acceptance cycle, never on the PENDING->RUN release
  always_comb begin
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    flush_if_id_o = accept_ex_c;
`else
    flush_if_id_o = redirect_c;
    flush_id_ex_o = accept_ex_c;
`endif
  end

  assign pc_o            = pc_q;
  assign pc_plus4_o      = pc_plus4_q;
  assign fetch_valid_o   = fetch_valid_q;
  assign redirect_busy_o = busy_q;
  assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed self-checking bench for pc_redirect_controller.
module tb_pc_redirect_controller;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        id_jump_i;
  logic [31:0] id_jump_target_i;
  logic        ex_redirect_i;
  logic [31:0] ex_target_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        redirect_busy_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic JMP_FIFD = 1'b0;
  localparam logic EX_FIDEX = 1'b0;
`else
  localparam logic JMP_FIFD = 1'b1;
  localparam logic EX_FIDEX = 1'b1;
`endif
  localparam logic EX_FIFD = 1'b1;

  pc_redirect_controller dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .id_jump_i        (id_jump_i),
    .id_jump_target_i (id_jump_target_i),
    .ex_redirect_i    (ex_redirect_i),
    .ex_target_i      (ex_target_i),
    .imem_ready_i     (imem_ready_i),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .fetch_valid_o    (fetch_valid_o),
    .flush_if_id_o    (flush_if_id_o),
    .flush_id_ex_o    (flush_id_ex_o),
    .redirect_busy_o  (redirect_busy_o),
    .misalign_o       (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset            = 1'b0;
    stall_i          = 1'b0;
    id_jump_i        = 1'b0;
    id_jump_target_i = 32'h0;
    ex_redirect_i    = 1'b0;
    ex_target_i      = 32'h0;
    imem_ready_i     = 1'b1;
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_fv", 32'(fetch_valid_o), 32'd0);
    chk("rst_busy", 32'(redirect_busy_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_fifd", 32'(flush_if_id_o), 32'd0);

    // Boot then sequential fetch
    reset = 1'b0;
    tick();
    chk("boot_fv", 32'(fetch_valid_o), 32'd1);
    chk("seq0", pc_o, 32'h0040_0000);
    tick();
    chk("seq1", pc_o, 32'h0040_0004);
    tick();
    chk("seq2", pc_o, 32'h0040_0008);
    chk("seq2_p4", pc_plus4_o, 32'h0040_000C);

    // ID jump
    id_jump_i = 1'b1; id_jump_target_i = 32'h0040_0100;
    #1;
    chk("jmp_fifd", 32'(flush_if_id_o), 32'(JMP_FIFD));
    chk("jmp_fidex", 32'(flush_id_ex_o), 32'd0);
    tick();
    id_jump_i = 1'b0;
    chk("jmp_pc", pc_o, 32'h0040_0100);
    chk("jmp_p4", pc_plus4_o, 32'h0040_0104);

    // EX redirect beats ID jump and stall
    ex_redirect_i = 1'b1; ex_target_i = 32'h0040_0040;
    id_jump_i = 1'b1; id_jump_target_i = 32'h0040_0100; stall_i = 1'b1;
    #1;
    chk("ex_fifd", 32'(flush_if_id_o), 32'(EX_FIFD));
    chk("ex_fidex", 32'(flush_id_ex_o), 32'(EX_FIDEX));
    tick();
    ex_redirect_i = 1'b0; id_jump_i = 1'b0;
    chk("ex_pc", pc_o, 32'h0040_0040);

    // Stall holds, then imem not ready holds
    tick();
    chk("stall_pc", pc_o, 32'h0040_0040);
    stall_i = 1'b0; imem_ready_i = 1'b0;
    tick();
    chk("nrdy_pc", pc_o, 32'h0040_0040);

    // Redirect while imem busy for 3 cycles -> PENDING
    ex_redirect_i = 1'b1; ex_target_i = 32'h0040_0200;
    #1;
    chk("pend_fifd", 32'(flush_if_id_o), 32'(EX_FIFD));
    tick();
    ex_redirect_i = 1'b0;
    chk("pend_busy", 32'(redirect_busy_o), 32'd1);
    chk("pend_fv", 32'(fetch_valid_o), 32'd0);
    chk("pend_pc", pc_o, 32'h0040_0040);
    id_jump_i = 1'b1; id_jump_target_i = 32'h0040_0100;
    #1;
    chk("pend_jmp_fifd", 32'(flush_if_id_o), 32'd0);
    tick();
    id_jump_i = 1'b0;
    chk("pend_jmp_pc", pc_o, 32'h0040_0040);
    chk("pend_jmp_busy", 32'(redirect_busy_o), 32'd1);
    tick();
    chk("pend3_pc", pc_o, 32'h0040_0040);
    imem_ready_i = 1'b1;
    #1;
    chk("rel_fifd", 32'(flush_if_id_o), 32'd0);
    chk("rel_fidex", 32'(flush_id_ex_o), 32'd0);
    tick();
    chk("rel_pc", pc_o, 32'h0040_0200);
    chk("rel_busy", 32'(redirect_busy_o), 32'd0);
    chk("rel_fv", 32'(fetch_valid_o), 32'd1);

    // Second EX redirect overwrites pending target
    imem_ready_i = 1'b0; ex_redirect_i = 1'b1; ex_target_i = 32'h0040_0280;
    tick();
    ex_target_i = 32'h0040_0300;
    #1;
    chk("ovr_fidex", 32'(flush_id_ex_o), 32'(EX_FIDEX));
    tick();
    ex_redirect_i = 1'b0;
    chk("ovr_busy", 32'(redirect_busy_o), 32'd1);
    chk("ovr_hold", pc_o, 32'h0040_0200);
    imem_ready_i = 1'b1;
    tick();
    chk("ovr_pc", pc_o, 32'h0040_0300);

    // Misaligned target
    ex_redirect_i = 1'b1; ex_target_i = 32'h0040_0203;
    tick();
    ex_redirect_i = 1'b0;
    chk("mis_pc", pc_o, 32'h0040_0200);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    tick();
    chk("mis_clr", 32'(misalign_o), 32'd0);
    chk("mis_seq", pc_o, 32'h0040_0204);

    // pc+4 wrap
    ex_redirect_i = 1'b1; ex_target_i = 32'hFFFF_FFFC;
    tick();
    ex_redirect_i = 1'b0;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4_o, 32'h0000_0000);
    tick();
    chk("wrap_next", pc_o, 32'h0000_0000);

    // Reset mid-PENDING
    imem_ready_i = 1'b0; ex_redirect_i = 1'b1; ex_target_i = 32'h0040_0040;
    tick();
    ex_redirect_i = 1'b0;
    chk("rp_busy", 32'(redirect_busy_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("rp_pc", pc_o, 32'h0040_0000);
    chk("rp_busy0", 32'(redirect_busy_o), 32'd0);
    chk("rp_fv", 32'(fetch_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
